// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types: score width, class count, controller state encoding.
// Used by the FC classify controller and by the classifier it feeds.
// Contents: LENET_DATA_SIZE, LENET_NUM_CLASS, LOAD_CNT_W, fc_state_e, slot_msb().
package lenet_pkg;

  localparam int LENET_DATA_SIZE = 8;   // width of one FC score and of a class index
  localparam int LENET_NUM_CLASS = 10;  // FC scores per frame
  localparam int LOAD_CNT_W      = 4;   // score slot counter width (frames up to 16 scores)

  // Binary-encoded controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } fc_state_e;

  // MSB position of score slot k in a packed buffer of n scores of w bits.
  // Slot 0 sits at the top of the buffer.
  function automatic int slot_msb(input int k, input int n, input int w);
    return (n - k) * w - 1;
  endfunction

endpackage

// File: rtl/fc_classify_ctrl.sv
// Purpose: collects NUM_CLASS FC scores into a packed buffer, enables the classifier,
//          captures its winning index and presents it downstream, with a result timeout.
// Latency: 7 cycles from last score transfer to res_vld when the classifier answers
//          on its 6th enabled cycle. Backpressure: fc_rdy is low while a frame is
//          being classified or its result waits in HOLD; res_vld holds until res_rdy.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   fc_vld/fc_rdy/fc_data        score input handshake
//   fc_result                    packed score buffer (slot 0 in the MSBs)
//   classify_en                  classifier enable, high for the whole classification
//   classify_res_vld/classify_res  classifier answer (only honoured in RUN)
//   res_vld/res_rdy/res_data     result output handshake
//   timeout_err                  one-cycle pulse when the classifier does not answer
//   busy                         high whenever the controller is not IDLE
module fc_classify_ctrl
  import lenet_pkg::*;
#(
  parameter int DATA_SIZE = LENET_DATA_SIZE,
  parameter int NUM_CLASS = LENET_NUM_CLASS,
  parameter int TIMEOUT   = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fc_vld,
  input  logic [DATA_SIZE-1:0]           fc_data,
  output logic                           fc_rdy,
  output logic [NUM_CLASS*DATA_SIZE-1:0] fc_result,
  output logic                           classify_en,
  input  logic                           classify_res_vld,
  input  logic [DATA_SIZE-1:0]           classify_res,
  output logic                           res_vld,
  output logic [DATA_SIZE-1:0]           res_data,
  input  logic                           res_rdy,
  output logic                           timeout_err,
  output logic                           busy
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [LOAD_CNT_W-1:0] LAST_SLOT = LOAD_CNT_W'(NUM_CLASS - 1);
  // Timeout fires on the edge where run_cnt would reach TIMEOUT.
  localparam logic [RUN_W-1:0]      RUN_LAST  = RUN_W'(TIMEOUT - 1);

  fc_state_e                      state_q;
  logic [LOAD_CNT_W-1:0]          load_cnt_q;
  logic [RUN_W-1:0]               run_cnt_q;
  logic [NUM_CLASS*DATA_SIZE-1:0] fc_result_q;
  logic [DATA_SIZE-1:0]           res_data_q;
  logic                           res_vld_q;
  logic                           classify_en_q;
  logic                           timeout_err_q;
  logic                           busy_q;
  logic                           fc_rdy_q;

  logic fc_xfer;

  // fc_rdy is a flop so it can read low during reset while the state is IDLE.
  assign fc_xfer = fc_vld & fc_rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      run_cnt_q     <= '0;
      fc_result_q   <= '0;
      res_data_q    <= '0;
      res_vld_q     <= 1'b0;
      classify_en_q <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      fc_rdy_q      <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;

      // Score write; fc_rdy is only high in IDLE/LOAD, so the buffer is frozen otherwise.
      if (fc_xfer) begin
        for (int k = 0; k < NUM_CLASS; k++) begin
          if (load_cnt_q == LOAD_CNT_W'(k)) begin
            fc_result_q[slot_msb(k, NUM_CLASS, DATA_SIZE) -: DATA_SIZE] <= fc_data;
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          fc_rdy_q <= 1'b1;
          busy_q   <= 1'b0;
          if (fc_xfer) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= LOAD_CNT_W'(1);
            busy_q     <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (fc_xfer) begin
            if (load_cnt_q == LAST_SLOT) begin
              state_q       <= ST_RUN;
              load_cnt_q    <= '0;
              run_cnt_q     <= '0;
              classify_en_q <= 1'b1;
              fc_rdy_q      <= 1'b0;
            end else begin
              load_cnt_q <= load_cnt_q + LOAD_CNT_W'(1);
            end
          end
        end

        ST_RUN: begin
          // A result on the timeout edge takes priority over the error.
          if (classify_res_vld) begin
            state_q       <= ST_HOLD;
            res_data_q    <= classify_res;
            res_vld_q     <= 1'b1;
            classify_en_q <= 1'b0;
            run_cnt_q     <= '0;
          end else if (run_cnt_q == RUN_LAST) begin
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
            classify_en_q <= 1'b0;
            run_cnt_q     <= '0;
            fc_rdy_q      <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_q + RUN_W'(1);
          end
        end

        ST_HOLD: begin
          if (res_vld_q && res_rdy) begin
            state_q   <= ST_IDLE;
            res_vld_q <= 1'b0;
            fc_rdy_q  <= 1'b1;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fc_rdy      = fc_rdy_q;
  assign fc_result   = fc_result_q;
  assign classify_en = classify_en_q;
  assign res_vld     = res_vld_q;
  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fc_classify_ctrl.sv
// Directed bench for fc_classify_ctrl with a registered classifier model.
// Inputs are driven and outputs sampled on the falling edge.
// Ports: all DUT ports connected by name.
module tb_fc_classify_ctrl;

  localparam int DS = 8;
  localparam int NC = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           fc_vld;
  logic [DS-1:0]  fc_data;
  logic           fc_rdy;
  logic [NC*DS-1:0] fc_result;
  logic           classify_en;
  logic           classify_res_vld;
  logic [DS-1:0]  classify_res;
  logic           res_vld;
  logic [DS-1:0]  res_data;
  logic           res_rdy;
  logic           timeout_err;
  logic           busy;

  always #5 clk = ~clk;

  fc_classify_ctrl #(.DATA_SIZE(DS), .NUM_CLASS(NC), .TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .fc_vld           (fc_vld),
    .fc_data          (fc_data),
    .fc_rdy           (fc_rdy),
    .fc_result        (fc_result),
    .classify_en      (classify_en),
    .classify_res_vld (classify_res_vld),
    .classify_res     (classify_res),
    .res_vld          (res_vld),
    .res_data         (res_data),
    .res_rdy          (res_rdy),
    .timeout_err      (timeout_err),
    .busy             (busy)
  );

  // Classifier model: counts enabled edges, answers (registered) on the answer_at-th.
  int            answer_at;
  bit            model_on;
  logic [DS-1:0] ans_base;
  int            model_cnt  = 0;
  int            model_nans = 0;
  logic          model_vld  = 1'b0;
  logic [DS-1:0] model_res  = '0;
  logic          stray_vld;

  always @(posedge clk) begin
    if (!classify_en) begin
      model_cnt <= 0;
      model_vld <= 1'b0;
    end else begin
      model_cnt <= model_cnt + 1;
      model_vld <= model_on && (model_cnt + 1 == answer_at);
      if (model_on && (model_cnt + 1 == answer_at)) begin
        model_res  <= ans_base + DS'(model_nans);
        model_nans <= model_nans + 1;
      end
    end
  end

  assign classify_res_vld = model_vld | stray_vld;
  assign classify_res     = stray_vld ? 8'h33 : model_res;

  // Monitors: accepted results, timeout pulses, classify_en rising edges.
  logic [DS-1:0] res_q[$];
  int            to_cnt  = 0;
  int            en_rise = 0;
  logic          en_prev = 1'b0;

  always @(posedge clk) begin
    if (res_vld && res_rdy) res_q.push_back(res_data);
    if (timeout_err) to_cnt <= to_cnt + 1;
  end

  always @(negedge clk) begin
    if (classify_en && !en_prev) en_rise++;
    en_prev = classify_en;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one score and return on the falling edge after it was taken.
  task automatic send(input logic [DS-1:0] d);
    int n = 0;
    fc_vld  = 1'b1;
    fc_data = d;
    while (!fc_rdy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!fc_rdy) begin
      check("send_stall", fc_rdy, 1'b1);
    end else begin
      @(negedge clk);
    end
    fc_vld = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_result(input logic [DS-1:0] exp);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    check("res_vld_cleared", res_vld, 1'b0);
    check("idle_after_take", busy, 1'b0);
    check("res_count", res_q.size(), 1);
    if (res_q.size() > 0) begin
      check("res_value", res_q[0], exp);
      res_q.delete();
    end
  endtask

  int            n;
  int            rise0;
  logic [DS-1:0] exp_ans;
  logic [NC*DS-1:0] held;

  initial begin
    rst = 1'b1; fc_vld = 1'b0; fc_data = '0; res_rdy = 1'b0; stray_vld = 1'b0;
    model_on = 1'b1; answer_at = 6; ans_base = 8'd9; exp_ans = 8'd9;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_fc_rdy", fc_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_classify_en", classify_en, 1'b0);
    check("rst_res_vld", res_vld, 1'b0);
    check("rst_res_data", res_data, 8'h0);
    check("rst_fc_result", fc_result, 80'h0);
    check("rst_timeout", timeout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_fc_rdy", fc_rdy, 1'b1);

    // Back-to-back frame, result held under backpressure
    for (int i = 0; i < NC; i++) send(DS'((i + 1) * 10));
    check("run_classify_en", classify_en, 1'b1);
    check("run_fc_rdy", fc_rdy, 1'b0);
    check("run_busy", busy, 1'b1);
    wait_res(n);
    check("latency", n, 7);
    check("res_vld", res_vld, 1'b1);
    check("res_data", res_data, exp_ans);
    check("fc_result", fc_result, 80'h0A141E28323C46505A64);
    check("hold_classify_en", classify_en, 1'b0);
    held = fc_result;
    fc_vld = 1'b1; fc_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_vld", res_vld, 1'b1);
      check("hold_res_data", res_data, exp_ans);
      check("hold_fc_rdy", fc_rdy, 1'b0);
    end
    fc_vld = 1'b0;
    check("hold_buf_kept", fc_result, held);
    take_result(exp_ans);
    exp_ans++;
    check("idle_rdy_again", fc_rdy, 1'b1);

    // Classifier never answers
    model_on = 1'b0;
    for (int i = 0; i < NC; i++) send(DS'(8'h21 + i));
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_delay", n, 15);
    check("timeout_pulse", timeout_err, 1'b1);
    check("timeout_en_low", classify_en, 1'b0);
    check("timeout_idle", busy, 1'b0);
    check("timeout_no_res", res_vld, 1'b0);
    @(negedge clk);
    check("timeout_one_cycle", timeout_err, 1'b0);
    check("timeout_count", to_cnt, 1);
    model_on = 1'b1;

    // Result on the same edge as the timeout: result wins
    answer_at = 14;
    for (int i = 0; i < NC; i++) send(DS'(8'h31 + i));
    wait_res(n);
    check("edge_latency", n, 15);
    check("edge_res_data", res_data, exp_ans);
    check("edge_no_timeout", timeout_err, 1'b0);
    check("edge_to_count", to_cnt, 1);
    take_result(exp_ans);
    exp_ans++;
    answer_at = 6;

    // Reset mid-frame, then a full new frame
    for (int i = 0; i < 4; i++) send(DS'(8'h11 + i));
    rst = 1'b1;
    #1;
    check("mid_rst_buf", fc_result, 80'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rdy", fc_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) send(DS'(i + 1));
    check("rst_frame_buf", fc_result, 80'h0102030405060708090A);
    wait_res(n);
    check("rst_frame_latency", n, 7);
    check("rst_frame_res", res_data, exp_ans);
    take_result(exp_ans);
    exp_ans++;
    check("rst_no_timeout", to_cnt, 1);

    // Gaps between scores and a stray classifier valid during LOAD
    for (int i = 0; i < NC; i++) begin
      send(DS'(8'hA0 + i));
      repeat (i % 3) @(negedge clk);
      if (i == 4) begin
        stray_vld = 1'b1;
        @(negedge clk);
        stray_vld = 1'b0;
        check("stray_no_res", res_vld, 1'b0);
        check("stray_still_load", fc_rdy, 1'b1);
        check("stray_busy", busy, 1'b1);
      end
    end
    check("gap_buf", fc_result, 80'hA0A1A2A3A4A5A6A7A8A9);
    wait_res(n);
    check("gap_latency", n, 7);
    check("gap_res", res_data, exp_ans);
    take_result(exp_ans);
    exp_ans++;

    // Two frames back-to-back with the result consumed at once
    res_rdy = 1'b1;
    rise0 = en_rise;
    for (int i = 0; i < 2 * NC; i++) send(DS'(8'h50 + i));
    n = 0;
    while (res_q.size() < 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b2b_res_count", res_q.size(), 2);
    if (res_q.size() >= 2) begin
      check("b2b_first", res_q[0], exp_ans);
      check("b2b_second", res_q[1], exp_ans + 8'd1);
    end
    check("b2b_en_rises", en_rise - rise0, 2);
    check("b2b_buf", fc_result, 80'h5A5B5C5D5E5F60616263);
    res_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_classify_ctrl.md
FC_CLASSIFY_CTRL -- requirements
Module: fc_classify_ctrl

Interface
REQ-001 Parameter DATA_SIZE, 8, width of one FC output score and of the class index.
REQ-002 Parameter NUM_CLASS, 10, number of FC scores per frame.
REQ-003 Parameter TIMEOUT, 15, maximum RUN-state cycles to wait for the classifier result.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 fc_vld  in  1  FC score present on fc_data.
REQ-007 fc_data  in  DATA_SIZE  unsigned FC score, neuron order 0..NUM_CLASS-1.
REQ-008 fc_rdy  out  1  controller accepts a score; a score transfers when fc_vld and fc_rdy are both high.
REQ-009 fc_result  out  NUM_CLASS*DATA_SIZE  packed score buffer to the classifier; neuron k occupies bits [(NUM_CLASS-k)*DATA_SIZE-1 : (NUM_CLASS-1-k)*DATA_SIZE].
REQ-010 classify_en  out  1  enable to the classifier, held high for the whole classification.
REQ-011 classify_res_vld  in  1  classifier result valid.
REQ-012 classify_res  in  DATA_SIZE  classifier winning index.
REQ-013 res_vld  out  1  result available downstream.
REQ-014 res_data  out  DATA_SIZE  captured class index.
REQ-015 res_rdy  in  1  downstream accepts; the result transfers when res_vld and res_rdy are both high.
REQ-016 timeout_err  out  1  one-cycle pulse when the classifier does not answer within TIMEOUT cycles.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN and HOLD, registered and binary encoded.
REQ-019 fc_rdy SHALL be high in IDLE and LOAD, and low in RUN and HOLD; scores offered in RUN/HOLD are not taken.
REQ-020 Each transfer SHALL write fc_data into slot load_cnt of fc_result and increment load_cnt, a 4-bit counter.
REQ-021 IDLE: on a transfer, go to LOAD with load_cnt=1; otherwise stay.
REQ-022 LOAD: on the transfer that makes load_cnt reach NUM_CLASS, go to RUN, clear load_cnt and set classify_en=1 on the same edge.
REQ-023 fc_result SHALL stay unchanged from entry into RUN until the next IDLE-to-LOAD transfer.
REQ-024 RUN: run_cnt increments each cycle; classify_en stays high.
REQ-025 RUN: on classify_res_vld=1, capture res_data<=classify_res, set res_vld=1, clear classify_en and go to HOLD on the same edge.
REQ-026 RUN: if run_cnt reaches TIMEOUT with no classify_res_vld, pulse timeout_err for one cycle, clear classify_en and go to IDLE; res_vld stays 0.
REQ-027 If classify_res_vld and the timeout occur on the same edge, the result wins and no error pulse is issued.
REQ-028 HOLD: res_vld and res_data stay stable until a transfer; on res_vld&res_rdy, clear res_vld and go to IDLE.
REQ-029 classify_en SHALL be low for at least one cycle between frames, so the classifier re-arms.
REQ-030 classify_res_vld outside RUN SHALL be ignored.
REQ-031 With the classifier answering on the 6th enabled cycle, frame latency SHALL be 7 cycles from the last score transfer to res_vld=1.

Reset
REQ-032 While rst=1: state=IDLE; load_cnt, run_cnt, fc_result, res_data=0; classify_en, res_vld, timeout_err, busy=0; fc_rdy=0.
REQ-033 Reset mid-frame SHALL discard partial scores and any pending result; no res_vld or timeout_err follows reset.

Structure
REQ-034 DATA_SIZE, NUM_CLASS and the state encoding SHALL live in a shared lenet package, also used by the classifier.
REQ-035 The block SHALL be a single module; it does not instantiate the classifier, which connects to it at the top level.

Verification
REQ-036 Scores 10,20,...,100 streamed back-to-back; classifier model answers 9 on the 6th enabled cycle -> fc_result=0x0A141E28323C46505A64, res_vld=1 with res_data=9, 7 cycles after the 10th transfer.
REQ-037 res_rdy held low for 5 cycles in HOLD -> res_vld/res_data stable; fc_rdy=0; a score offered in that window is not accepted.
REQ-038 Classifier model never answers -> timeout_err pulses once, TIMEOUT cycles after RUN entry; classify_en falls; FSM back in IDLE.
REQ-039 rst pulsed after 4 scores, then a full new frame sent -> the new frame alone fills fc_result and produces exactly one result.
REQ-040 fc_vld gaps between scores, and a stray classify_res_vld in LOAD -> the loaded buffer is correct, and the stray valid is ignored.
REQ-041 Two frames back-to-back with res_rdy=1 -> classify_en goes low for at least one cycle between frames; two results in order.
